// File: rtl/netlist_compare_checker_pkg.sv
// Shared types and helpers for the golden-vs-netlist output checker.
package netlist_cmp_pkg;

  localparam int MAX_GOLD_DELAY = 15;
  localparam int MAX_WIDTH      = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } cmp_state_e;

  // Callers zero-extend narrower buses; the extra bits compare equal, so the mask value there is irrelevant.
  function automatic logic masked_mismatch(input logic [MAX_WIDTH-1:0] golden,
                                           input logic [MAX_WIDTH-1:0] dut,
                                           input logic [MAX_WIDTH-1:0] mask);
    return |((golden ^ dut) & ~mask);
  endfunction

endpackage

// File: rtl/netlist_compare_checker_delay_line.sv
// Golden data + valid delay line; depth 0 is a plain wire.
module cmp_delay_line #(
  parameter int WIDTH      = 32,
  parameter int GOLD_DELAY = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  generate
    if (GOLD_DELAY == 0) begin : g_thru
      logic unused_thru;
      assign unused_thru = ^{clk_i, rst_ni, clr_i};
      assign vld_o = vld_i;
      assign dat_o = dat_i;
    end else begin : g_pipe
      logic [GOLD_DELAY-1:0]            vld_pipe;
      logic [GOLD_DELAY-1:0][WIDTH-1:0] dat_pipe;

      // Data keeps shifting through start; only the valid bits are flushed.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else begin
          vld_pipe[0] <= vld_i & ~clr_i;
          dat_pipe[0] <= dat_i;
          for (int k = 1; k < GOLD_DELAY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1] & ~clr_i;
            dat_pipe[k] <= dat_pipe[k-1];
          end
        end
      end

      assign vld_o = vld_pipe[GOLD_DELAY-1];
      assign dat_o = dat_pipe[GOLD_DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/netlist_compare_checker.sv
// Golden-vs-netlist checker: aligns golden, masked compare, counts, first-fail capture.
module netlist_compare_checker
  import netlist_cmp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int GOLD_DELAY  = 0,
  parameter int WARMUP      = 1,
  parameter int MAX_SAMPLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             sample_valid_i,
  input  logic [WIDTH-1:0] golden_i,
  input  logic [WIDTH-1:0] dut_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_pulse_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic             first_fail_valid_o,
  output logic [CNT_W-1:0] first_fail_idx_o,
  output logic [WIDTH-1:0] first_fail_golden_o,
  output logic [WIDTH-1:0] first_fail_dut_o
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_SAMPLES);
  localparam bit               HAS_MAX = (MAX_SAMPLES != 0);
  localparam logic [8:0]       WARM_N  = 9'(WARMUP);

  cmp_state_e state_q, state_d;

  logic             al_vld;
  logic [WIDTH-1:0] gold_dly;
  logic             mism, check_en, warm_last, cnt_last;

  logic [7:0]       warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic             ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_gold_q, ff_gold_d;
  logic [WIDTH-1:0] ff_dut_q, ff_dut_d;

  cmp_delay_line #(
    .WIDTH      (WIDTH),
    .GOLD_DELAY (GOLD_DELAY)
  ) u_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_i),
    .vld_i  (sample_valid_i),
    .dat_i  (golden_i),
    .vld_o  (al_vld),
    .dat_o  (gold_dly)
  );

  assign mism      = masked_mismatch(MAX_WIDTH'(gold_dly), MAX_WIDTH'(dut_i), MAX_WIDTH'(mask_i));
  assign check_en  = (state_q == ST_CHECK) && al_vld;
  assign warm_last = ({1'b0, warm_cnt_q} + 9'd1) == WARM_N;
  assign cnt_last  = HAS_MAX && ((sample_cnt_q + CNT_W'(1)) == MAX_C);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: if (stop_i) state_d = ST_DONE;
                   else if (al_vld && warm_last) state_d = ST_CHECK;
        ST_CHECK:  if (stop_i || (al_vld && cnt_last)) state_d = ST_DONE;
        default:   ;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == ST_WARMUP) || (state_q == ST_CHECK);
    done_o = (state_q == ST_DONE);
    pass_o = done_o && (mismatch_cnt_q == '0);
  end

  always_comb begin
    warm_cnt_d     = warm_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    fail_pulse_d   = 1'b0;
    ff_valid_d     = ff_valid_q;
    ff_idx_d       = ff_idx_q;
    ff_gold_d      = ff_gold_q;
    ff_dut_d       = ff_dut_q;
    if (start_i) begin
      warm_cnt_d     = '0;
      sample_cnt_d   = '0;
      mismatch_cnt_d = '0;
      ff_valid_d     = 1'b0;
      ff_idx_d       = '0;
      ff_gold_d      = '0;
      ff_dut_d       = '0;
    end else begin
      if (state_q == ST_WARMUP && al_vld) warm_cnt_d = warm_cnt_q + 8'd1;
      if (check_en) begin
        // Without a sample budget the counter parks at all-ones instead of wrapping.
        if (HAS_MAX || sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
        if (mism) begin
          fail_pulse_d = 1'b1;
          if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = sample_cnt_q;
            ff_gold_d  = gold_dly;
            ff_dut_d   = dut_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_cnt_q     <= '0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      fail_pulse_q   <= 1'b0;
      ff_valid_q     <= 1'b0;
      ff_idx_q       <= '0;
      ff_gold_q      <= '0;
      ff_dut_q       <= '0;
    end else begin
      warm_cnt_q     <= warm_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      fail_pulse_q   <= fail_pulse_d;
      ff_valid_q     <= ff_valid_d;
      ff_idx_q       <= ff_idx_d;
      ff_gold_q      <= ff_gold_d;
      ff_dut_q       <= ff_dut_d;
    end
  end

  assign fail_pulse_o        = fail_pulse_q;
  assign sample_cnt_o        = sample_cnt_q;
  assign mismatch_cnt_o      = mismatch_cnt_q;
  assign first_fail_valid_o  = ff_valid_q;
  assign first_fail_idx_o    = ff_idx_q;
  assign first_fail_golden_o = ff_gold_q;
  assign first_fail_dut_o    = ff_dut_q;

endmodule

// File: tb/tb_netlist_compare_checker.sv
// Directed bench: three checker configurations driven from one sequence.
module tb_netlist_compare_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: D=0, WARMUP=1, MAX=1000
  logic a_start = 0, a_stop = 0, a_vld = 0;
  logic [31:0] a_gold = 0, a_dut = 0, a_mask = 0;
  logic a_busy, a_done, a_pass, a_fp, a_ffv;
  logic [15:0] a_scnt, a_mcnt, a_ffi;
  logic [31:0] a_ffg, a_ffd;

  // b: D=2, WARMUP=1, MAX=20
  logic b_start = 0, b_stop = 0, b_vld = 0;
  logic [31:0] b_gold = 0, b_dut = 0, b_mask = 0;
  logic b_busy, b_done, b_pass, b_fp, b_ffv;
  logic [15:0] b_scnt, b_mcnt, b_ffi;
  logic [31:0] b_ffg, b_ffd;

  // c: CNT_W=4, D=0, WARMUP=0, MAX=0
  logic c_start = 0, c_stop = 0, c_vld = 0;
  logic [7:0] c_gold = 0, c_dut = 0, c_mask = 0;
  logic c_busy, c_done, c_pass, c_fp, c_ffv;
  logic [3:0] c_scnt, c_mcnt, c_ffi;
  logic [7:0] c_ffg, c_ffd;

  netlist_compare_checker #(.WIDTH(32), .GOLD_DELAY(0), .WARMUP(1), .MAX_SAMPLES(1000), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .stop_i(a_stop), .sample_valid_i(a_vld),
    .golden_i(a_gold), .dut_i(a_dut), .mask_i(a_mask), .busy_o(a_busy), .done_o(a_done),
    .pass_o(a_pass), .fail_pulse_o(a_fp), .sample_cnt_o(a_scnt), .mismatch_cnt_o(a_mcnt),
    .first_fail_valid_o(a_ffv), .first_fail_idx_o(a_ffi), .first_fail_golden_o(a_ffg),
    .first_fail_dut_o(a_ffd));

  netlist_compare_checker #(.WIDTH(32), .GOLD_DELAY(2), .WARMUP(1), .MAX_SAMPLES(20), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .stop_i(b_stop), .sample_valid_i(b_vld),
    .golden_i(b_gold), .dut_i(b_dut), .mask_i(b_mask), .busy_o(b_busy), .done_o(b_done),
    .pass_o(b_pass), .fail_pulse_o(b_fp), .sample_cnt_o(b_scnt), .mismatch_cnt_o(b_mcnt),
    .first_fail_valid_o(b_ffv), .first_fail_idx_o(b_ffi), .first_fail_golden_o(b_ffg),
    .first_fail_dut_o(b_ffd));

  netlist_compare_checker #(.WIDTH(8), .GOLD_DELAY(0), .WARMUP(0), .MAX_SAMPLES(0), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(c_start), .stop_i(c_stop), .sample_valid_i(c_vld),
    .golden_i(c_gold), .dut_i(c_dut), .mask_i(c_mask), .busy_o(c_busy), .done_o(c_done),
    .pass_o(c_pass), .fail_pulse_o(c_fp), .sample_cnt_o(c_scnt), .mismatch_cnt_o(c_mcnt),
    .first_fail_valid_o(c_ffv), .first_fail_idx_o(c_ffi), .first_fail_golden_o(c_ffg),
    .first_fail_dut_o(c_ffd));

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gv(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  // Golden at cycle k, dut = golden two cycles earlier; bit 5 flipped at cycle 13
  // (aligned sample 11 = checked sample 10 after one warmup sample).
  task automatic run_b(input logic [31:0] mk, output int npulse, output int pulse_at);
    b_start = 1; tick; b_start = 0;
    npulse = 0; pulse_at = -1;
    for (int k = 0; k < 25; k++) begin
      b_vld  = (k <= 20);
      b_gold = gv(k);
      b_dut  = (k >= 2) ? gv(k - 2) : 32'h0;
      b_mask = 32'h0;
      if (k == 13) begin
        b_dut  = b_dut ^ 32'h20;
        b_mask = mk;
      end
      tick;
      if (b_fp) begin npulse++; pulse_at = k; end
    end
    b_vld = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fp, np, pat;
    logic [31:0] cap_g;

    #12;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_pass", a_pass, 0);
    chk("rst_a_scnt", a_scnt, 0);
    chk("rst_a_mcnt", a_mcnt, 0);
    chk("rst_a_ffv", a_ffv, 0);
    chk("rst_b_fp", b_fp, 0);
    chk("rst_c_ffi", c_ffi, 0);
    @(negedge clk); rst_n = 1;
    tick;

    // stop is ignored in IDLE
    c_stop = 1; tick; c_stop = 0;
    chk("c_stop_idle_done", c_done, 0);
    chk("c_stop_idle_busy", c_busy, 0);

    // clean run: 1 warmup + 1000 checked samples
    a_start = 1; tick; a_start = 0;
    chk("a_start_busy", a_busy, 1);
    chk("a_start_done", a_done, 0);
    fp = 0;
    for (int i = 0; i <= 1000; i++) begin
      a_vld = 1; a_gold = $urandom; a_dut = a_gold; a_mask = 0;
      tick;
      fp += int'(a_fp);
    end
    chk("a_clean_done", a_done, 1);
    chk("a_clean_pass", a_pass, 1);
    chk("a_clean_busy", a_busy, 0);
    chk("a_clean_scnt", a_scnt, 1000);
    chk("a_clean_mcnt", a_mcnt, 0);
    chk("a_clean_ffv", a_ffv, 0);
    chk("a_clean_pulses", fp, 0);
    // samples in DONE are ignored, even mismatching ones
    for (int i = 0; i < 5; i++) begin
      a_gold = $urandom; a_dut = ~a_gold; tick;
    end
    a_vld = 0;
    chk("a_done_hold_scnt", a_scnt, 1000);
    chk("a_done_hold_mcnt", a_mcnt, 0);

    // restart, then start+stop together at checked sample 300
    a_start = 1; tick; a_start = 0;
    for (int i = 0; i <= 300; i++) begin
      a_vld = 1; a_gold = $urandom; a_dut = a_gold; tick;
    end
    chk("a_pre_restart_scnt", a_scnt, 300);
    a_start = 1; a_stop = 1; a_gold = $urandom; a_dut = ~a_gold; tick;
    a_start = 0; a_stop = 0;
    chk("a_restart_scnt", a_scnt, 0);
    chk("a_restart_busy", a_busy, 1);
    chk("a_restart_done", a_done, 0);
    chk("a_restart_mcnt", a_mcnt, 0);

    // run to 500 with one mismatch at checked sample 100, then async reset
    cap_g = 0;
    for (int i = 0; i <= 500; i++) begin
      a_vld = 1; a_gold = $urandom; a_dut = a_gold;
      if (i == 101) begin a_dut = a_gold ^ 32'h1; cap_g = a_gold; end
      tick;
    end
    a_vld = 0;
    chk("a_500_scnt", a_scnt, 500);
    chk("a_500_mcnt", a_mcnt, 1);
    chk("a_500_ffv", a_ffv, 1);
    chk("a_500_ffi", a_ffi, 100);
    chk("a_500_ffg", a_ffg, cap_g);
    chk("a_500_ffd", a_ffd, cap_g ^ 32'h1);
    #2 rst_n = 0;
    #1;
    chk("a_async_scnt", a_scnt, 0);
    chk("a_async_mcnt", a_mcnt, 0);
    chk("a_async_ffv", a_ffv, 0);
    chk("a_async_ffg", a_ffg, 0);
    chk("a_async_busy", a_busy, 0);
    @(negedge clk); rst_n = 1;
    tick; tick;
    chk("a_post_rst_done", a_done, 0);
    chk("a_post_rst_busy", a_busy, 0);

    // delayed golden, bit 5 corrupted at checked sample 10
    run_b(32'h0, np, pat);
    chk("b_pulses", np, 1);
    chk("b_pulse_cycle", pat, 13);
    chk("b_done", b_done, 1);
    chk("b_pass", b_pass, 0);
    chk("b_scnt", b_scnt, 20);
    chk("b_mcnt", b_mcnt, 1);
    chk("b_ffi", b_ffi, 10);
    chk("b_ff_xor", b_ffg ^ b_ffd, 32'h20);
    chk("b_ffg", b_ffg, gv(11));

    // same corruption, masked away
    run_b(32'h20, np, pat);
    chk("bm_pulses", np, 0);
    chk("bm_pass", b_pass, 1);
    chk("bm_scnt", b_scnt, 20);
    chk("bm_mcnt", b_mcnt, 0);
    chk("bm_ffv", b_ffv, 0);

    // 4-bit counters saturate, unbounded run ended by stop
    c_start = 1; tick; c_start = 0;
    chk("c_start_busy", c_busy, 1);
    np = 0;
    for (int k = 0; k < 20; k++) begin
      c_vld = 1; c_gold = 8'(k); c_dut = ~8'(k); c_mask = 0;
      tick;
      np += int'(c_fp);
    end
    c_vld = 0;
    c_stop = 1; tick; c_stop = 0;
    chk("c_pulses", np, 20);
    chk("c_mcnt_sat", c_mcnt, 15);
    chk("c_scnt_sat", c_scnt, 15);
    chk("c_done", c_done, 1);
    chk("c_pass", c_pass, 0);
    chk("c_busy", c_busy, 0);
    chk("c_ffi", c_ffi, 0);
    chk("c_ffd", c_ffd, 8'hff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
